// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feeder and result collector:
// default element width, sequencer state encoding and a width helper.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } feed_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Write/start/stream bundle of the operand feeder. The master side drives buffer
// writes and start; the slave side (the feeder) returns the skewed lanes and status.
interface systolic_operand_feeder_if #(
  parameter int DATA_WIDTH = systolic_pkg::DEF_DATA_WIDTH,
  parameter int LANES      = 4,
  parameter int DEPTH      = 8
);
  import systolic_pkg::*;

  localparam int LANE_W = clog2w(LANES);
  localparam int IDX_W  = clog2w(DEPTH);
  localparam int LEN_W  = clog2w(DEPTH + 1);

  logic                        wr_en;
  logic [LANE_W-1:0]           wr_lane;
  logic [IDX_W-1:0]            wr_idx;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic                        start;
  logic [LEN_W-1:0]            len;
  logic [LANES*DATA_WIDTH-1:0] data_out;
  logic [LANES-1:0]            load_out;
  logic                        busy;
  logic                        done;

  modport master (
    output wr_en, wr_lane, wr_idx, wr_data, start, len,
    input  data_out, load_out, busy, done
  );

  modport slave (
    input  wr_en, wr_lane, wr_idx, wr_data, start, len,
    output data_out, load_out, busy, done
  );

endinterface

// File: rtl/feeder_lane.sv
// One feeder lane: DEPTH-entry operand buffer, skew-window compare against the
// shared step counter, and the registered lane output with its load strobe.
module feeder_lane import systolic_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int LANE       = 0,
  parameter int IDX_W      = 3,
  parameter int CNT_W      = 4,
  parameter int LEN_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  issue,
  input  logic [CNT_W-1:0]      step,
  input  logic [LEN_W-1:0]      len,
  output logic [DATA_WIDTH-1:0] data_p1,
  output logic                  vld_p1
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_win;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Stage p0: window test and element select; a same-edge write is forwarded
  // so a stream started together with a write sees the new value.
  always_comb begin
    in_win = (int'(step) >= LANE) && (int'(step) < LANE + int'(len));
    rd_idx = '0;
    if (in_win) rd_idx = IDX_W'(step - CNT_W'(LANE));
    rd_val = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
  end

  // Stage p1: registered lane output, zero whenever the lane carries no beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (issue && in_win) begin
      vld_p1  <= 1'b1;
      data_p1 <= rd_val;
    end else begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for one systolic array edge: buffers per-lane vectors, streams
// them with diagonal skew, drains, then pulses done.
module systolic_operand_feeder import systolic_pkg::*; #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int LANES        = 4,
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input logic                     clk,
  input logic                     rst,
  systolic_operand_feeder_if.slave bus
);

  localparam int IDX_W = clog2w(DEPTH);
  localparam int LEN_W = clog2w(DEPTH + 1);
  localparam int CNT_W = clog2w(DEPTH + LANES);
  localparam int DRN_W = clog2w(DRAIN_CYCLES + 1);

  feed_state_e      state;
  logic [CNT_W-1:0] step;
  logic [LEN_W-1:0] len_l;
  logic [DRN_W-1:0] drn;
  logic             busy_r;
  logic             done_r;

  logic             len_ok;
  logic             last_step;
  logic             wr_ok;
  logic             issue;
  logic [CNT_W-1:0] step_nxt;
  logic [LEN_W-1:0] len_nxt;

  logic [LANES-1:0][DATA_WIDTH-1:0] lane_data;
  logic [LANES-1:0]                 lane_vld;

  // The lanes register the step about to be shown, so the first beat is
  // issued on the start edge itself and each STREAM cycle issues the next.
  always_comb begin
    len_ok    = (bus.len != '0) && (int'(bus.len) <= DEPTH);
    last_step = (int'(step) == int'(len_l) + LANES - 2);
    wr_ok     = (state == ST_IDLE) && bus.wr_en &&
                (int'(bus.wr_lane) < LANES) && (int'(bus.wr_idx) < DEPTH);
    issue     = 1'b0;
    step_nxt  = '0;
    len_nxt   = len_l;
    if (state == ST_IDLE) begin
      issue   = bus.start && len_ok;
      len_nxt = bus.len;
    end else if (state == ST_STREAM) begin
      issue    = !last_step;
      step_nxt = step + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      step   <= '0;
      len_l  <= '0;
      drn    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            if (len_ok) begin
              state <= ST_STREAM;
              len_l <= bus.len;
              step  <= '0;
            end else begin
              state  <= ST_FIN;
              done_r <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (last_step) begin
            drn <= '0;
            if (DRAIN_CYCLES == 0) begin
              state  <= ST_FIN;
              done_r <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            step <= step_nxt;
          end
        end
        ST_DRAIN: begin
          if (int'(drn) + 1 >= DRAIN_CYCLES) begin
            state  <= ST_FIN;
            done_r <= 1'b1;
          end else begin
            drn <= drn + DRN_W'(1);
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    feeder_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .LANE      (g),
      .IDX_W     (IDX_W),
      .CNT_W     (CNT_W),
      .LEN_W     (LEN_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_ok && (int'(bus.wr_lane) == g)),
      .wr_idx (bus.wr_idx),
      .wr_data(bus.wr_data),
      .issue  (issue),
      .step   (step_nxt),
      .len    (len_nxt),
      .data_p1(lane_data[g]),
      .vld_p1 (lane_vld[g])
    );
  end

  assign bus.data_out = lane_data;
  assign bus.load_out = lane_vld;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Bench for systolic_operand_feeder: table-driven stream lengths, same-edge and
// busy-time corner sequences, mid-stream reset and random buffers vs a cycle model.
module tb_systolic_operand_feeder;
  import systolic_pkg::*;

  localparam int DW     = 32;
  localparam int LN     = 4;
  localparam int DP     = 8;
  localparam int DRN    = 2;
  localparam int VW     = LN * DW;
  localparam int LANE_W = clog2w(LN);
  localparam int IDX_W  = clog2w(DP);
  localparam int LEN_W  = clog2w(DP + 1);
  localparam int MAXC   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_operand_feeder_if #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP)) bus ();

  systolic_operand_feeder #(
    .DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP), .DRAIN_CYCLES(DRN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] ref_mem [LN][DP];

  typedef struct {
    int len;
    int beats;
    int done_cyc;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs c cycles after the start edge, from the stream rules.
  task automatic model(input int l, input int c, output logic [VW-1:0] d,
                       output logic [LN-1:0] ld, output logic bz, output logic dn);
    int ns;
    d = '0; ld = '0; bz = 1'b0; dn = 1'b0;
    if (l < 1 || l > DP) begin
      if (c == 1) begin bz = 1'b1; dn = 1'b1; end
    end else begin
      ns = l + LN - 1;
      if (c <= ns) begin
        bz = 1'b1;
        for (int i = 0; i < LN; i++) begin
          int k;
          k = c - 1 - i;
          if (k >= 0 && k < l) begin
            ld[i] = 1'b1;
            d[i*DW +: DW] = ref_mem[i][k];
          end
        end
      end else if (c <= ns + DRN) begin
        bz = 1'b1;
      end else if (c == ns + DRN + 1) begin
        bz = 1'b1; dn = 1'b1;
      end
    end
  endtask

  task automatic wr(input int lane, input int idx, input logic [DW-1:0] v);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_lane = LANE_W'(lane); bus.wr_idx = IDX_W'(idx); bus.wr_data = v;
    ref_mem[lane][idx] = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // mode 1: same-edge write of 0xAA to lane 0 idx 0; mode 2: write and start while busy.
  task automatic run(input int l, input int mode, output int beats, output int done_cyc);
    logic [VW-1:0] d;
    logic [LN-1:0] ld;
    logic bz, dn;
    beats = 0; done_cyc = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.len = LEN_W'(l);
    if (mode == 1) begin
      bus.wr_en = 1'b1; bus.wr_lane = '0; bus.wr_idx = '0; bus.wr_data = 32'hAA;
      ref_mem[0][0] = 32'hAA;
    end
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      model(l, c, d, ld, bz, dn);
      chk($sformatf("data l=%0d m=%0d c=%0d", l, mode, c), bus.data_out, d);
      chk($sformatf("load l=%0d m=%0d c=%0d", l, mode, c), VW'(bus.load_out), VW'(ld));
      chk($sformatf("busy l=%0d m=%0d c=%0d", l, mode, c), VW'(bus.busy), VW'(bz));
      chk($sformatf("done l=%0d m=%0d c=%0d", l, mode, c), VW'(bus.done), VW'(dn));
      beats += $countones(bus.load_out);
      if (bus.done) done_cyc = c;
      if (c == 1) begin bus.start = 1'b0; bus.wr_en = 1'b0; end
      if (mode == 2 && c == 2) begin
        bus.wr_en = 1'b1; bus.wr_lane = LANE_W'(1); bus.wr_idx = '0; bus.wr_data = 32'h55;
        bus.start = 1'b1; bus.len = LEN_W'(1);
      end
      if (mode == 2 && c == 3) begin bus.wr_en = 1'b0; bus.start = 1'b0; end
    end
  endtask

  initial begin
    int b, dc, l;
    vecs[0] = '{3, 12, 9};
    vecs[1] = '{1, 4, 7};
    vecs[2] = '{8, 32, 14};
    vecs[3] = '{0, 0, 1};
    vecs[4] = '{9, 0, 1};
    vecs[5] = '{15, 0, 1};

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_lane = '0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.len = '0;
    repeat (3) @(negedge clk);
    chk("reset data", bus.data_out, '0);
    chk("reset load", VW'(bus.load_out), '0);
    chk("reset busy", VW'(bus.busy), '0);
    chk("reset done", VW'(bus.done), '0);
    rst = 1'b0;

    for (int i = 0; i < LN; i++)
      for (int k = 0; k < DP; k++)
        wr(i, k, DW'(16 * i + k));

    for (int v = 0; v < 6; v++) begin
      run(vecs[v].len, 0, b, dc);
      chk_int($sformatf("beats len=%0d", vecs[v].len), b, vecs[v].beats);
      chk_int($sformatf("done_cycle len=%0d", vecs[v].len), dc, vecs[v].done_cyc);
    end

    run(1, 1, b, dc);
    chk_int("same_edge done_cycle", dc, 7);
    run(2, 2, b, dc);
    chk_int("busy_start done_cycle", dc, 8);
    run(2, 0, b, dc);
    chk_int("after_busy_write beats", b, 8);

    // Reset three cycles into a len=8 stream.
    @(negedge clk);
    bus.start = 1'b1; bus.len = LEN_W'(8);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst pre busy", VW'(bus.busy), VW'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst data", bus.data_out, '0);
    chk("midrst load", VW'(bus.load_out), '0);
    chk("midrst busy", VW'(bus.busy), '0);
    chk("midrst done", VW'(bus.done), '0);
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      chk($sformatf("midrst idle c=%0d", c), VW'({bus.busy, bus.done, bus.load_out}), '0);
    end
    run(2, 0, b, dc);
    chk_int("post_rst beats", b, 8);

    for (int i = 0; i < LN; i++)
      for (int k = 0; k < DP; k++)
        wr(i, k, DW'($urandom));
    for (int r = 0; r < 10; r++) begin
      l = int'($urandom_range(0, 10));
      run(l, 0, b, dc);
      chk_int($sformatf("rand beats len=%0d", l), b, (l >= 1 && l <= DP) ? LN * l : 0);
      chk_int($sformatf("rand done_cycle len=%0d", l), dc,
              (l >= 1 && l <= DP) ? l + LN - 1 + DRN + 1 : 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Operand source for one edge of the systolic MAC array.
- Buffers one operand vector per lane, then streams the vectors into the array with diagonal skew, asserting each lane's load strobe only while that lane carries valid data.
- After streaming, holds all load strobes low for a drain window so the PEs present their accumulated results, then pulses done.
- Two instances, one per array edge (A rows, B columns), drive the PE A_in/B_in/load inputs.

Parameters:
- DATA_WIDTH, 32, width of one operand element.
- LANES, 4, number of parallel output lanes (array rows or columns).
- DEPTH, 8, maximum elements buffered per lane (maximum stream length).
- DRAIN_CYCLES, 2, cycles with all loads low between the last data beat and done.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe into the operand buffer.
- wr_lane  input  clog2(LANES)  lane index for the write.
- wr_idx  input  clog2(DEPTH)  element index for the write.
- wr_data  input  DATA_WIDTH  element value.
- start  input  1  begin a stream; sampled only in IDLE.
- len  input  clog2(DEPTH+1)  elements per lane; latched when start is accepted.
- data_out  output  LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- load_out  output  LANES  per-lane load strobe to the PE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of the sequence.

Behaviour:
- Reset: state=IDLE; data_out, load_out, busy, done, the step counter and the latched length all 0. Buffer contents are not cleared.
- Reset mid-stream aborts immediately: outputs are 0 on the cycle after the rst edge; no done pulse.
- All outputs are registered.
- Writes: accepted only in IDLE. mem[wr_lane][wr_idx] <= wr_data. Writes while busy are dropped. Out-of-range wr_lane or wr_idx is dropped.
- FSM states: IDLE, STREAM, DRAIN, FIN.
- IDLE to STREAM: start=1 and len in 1..DEPTH. On that edge, latch L=len and clear step counter t=0.
- Out-of-range start: start with len=0 or len>DEPTH goes IDLE to FIN, so done pulses with no data beats.
- start while busy is ignored.
- Same-edge start and wr_en in IDLE: the write commits. The stream reads the buffer from the next cycle, so it sees the new value.
- STREAM, for each step t = 0 .. L+LANES-2 (one step per cycle):
  - If i <= t < i+L: load_out[i]=1 and lane i = mem[i][t-i].
  - Otherwise: load_out[i]=0 and lane i = 0.
- Stream timing: the first beat (lane 0, element 0) is visible in the cycle after the start edge. Total STREAM length is L+LANES-1 cycles. The last beat is lane LANES-1, element L-1.
- STREAM to DRAIN: when t = L+LANES-2 has been issued.
- DRAIN: load_out=0 and data_out=0 for exactly DRAIN_CYCLES cycles, then FIN.
- DRAIN_CYCLES=0: STREAM goes directly to FIN.
- FIN: done=1 for one cycle, busy=1, then IDLE. busy drops in the same cycle done falls.
- Width rules: the counter is wide enough for DEPTH+LANES-1. The element index t-i is computed only when in range, so there is no wrap.

Decomposition:
- Shared package systolic_pkg: DATA_WIDTH default, the state encoding (IDLE/STREAM/DRAIN/FIN), and a clog2-based width helper. The package is reused by the result collector.
- One natural sub-module, feeder_lane: the per-lane buffer of DEPTH elements plus skew-offset compare and output register. It is parameterised by lane index, and LANES copies are generated.
- The top level holds the FSM and the shared step counter.

Test Plan:
- Write lane i element k = 16*i+k (LANES=4), then start with len=3:
  - Lane 0 loads 0,1,2 at cycles 1-3.
  - Lane 3 loads 48,49,50 at cycles 4-6.
  - Loads low for 2 drain cycles (7-8).
  - done high at cycle 9; busy high for cycles 1-9.
- Start with len=0: no load_out ever high; done pulses in the cycle after start.
- Start with len=9: same as len=0.
- Assert start and wr_en (lane 0, idx 0, value 0xAA) on the same edge with len=1: lane 0 emits 0xAA on cycle 1.
- wr_en during STREAM overwrites lane 1, idx 0 with 0x55: the write is dropped, and the next stream still emits the old value.
- Assert rst at cycle 3 of a len=8 stream: all outputs 0 from the next cycle; state IDLE; no done pulse. A new start with len=2 streams the original buffer contents correctly.
